// File: rtl/rx_control.sv
// rx_control: receive-side command decoder driving register-file and ALU.
// In: CLK, RST, Rx_Data/Rx_Data_valid, Rd_valid, ALU_out_valid.
// Out: WrEN, RdEN, Address, WrData, ALU_EN, ALU_FUN, Clk_gate_EN, Cmd_error.
module rx_control #(
  parameter int width      = 8,
  parameter int addr_width = 4,
  parameter int timeout    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [width-1:0]      Rx_Data,
  input  logic                  Rx_Data_valid,
  input  logic                  Rd_valid,
  input  logic                  ALU_out_valid,
  output logic                  WrEN,
  output logic                  RdEN,
  output logic [addr_width-1:0] Address,
  output logic [width-1:0]      WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  Clk_gate_EN,
  output logic                  Cmd_error
);

  localparam int CW = $clog2(timeout + 1);
  localparam logic [CW-1:0] LIMIT = CW'(timeout);

  localparam logic [width-1:0] CMD_WR  = width'(8'hAA);
  localparam logic [width-1:0] CMD_RD  = width'(8'hBB);
  localparam logic [width-1:0] CMD_OPS = width'(8'hCC);
  localparam logic [width-1:0] CMD_FUN = width'(8'hDD);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    FUN,
    ALU_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          resp;

  // Response that ends the current wait state.
  assign resp = (state == RD_WAIT) ? Rd_valid : ALU_out_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      WrEN        <= 1'b0;
      RdEN        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      Clk_gate_EN <= 1'b0;
      Cmd_error   <= 1'b0;
    end else begin
      WrEN      <= 1'b0;
      RdEN      <= 1'b0;
      ALU_EN    <= 1'b0;
      Cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          if (Rx_Data_valid) begin
            unique case (1'b1)
              (Rx_Data == CMD_WR): state <= WR_ADDR;
              (Rx_Data == CMD_RD): state <= RD_ADDR;
              (Rx_Data == CMD_OPS): begin
                state       <= OP_A;
                Clk_gate_EN <= 1'b1;
              end
              (Rx_Data == CMD_FUN): begin
                state       <= FUN;
                Clk_gate_EN <= 1'b1;
              end
              default: Cmd_error <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (Rx_Data_valid) begin
            Address <= Rx_Data[addr_width-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (Rx_Data_valid) begin
            WrData <= Rx_Data;
            WrEN   <= 1'b1;
            state  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (Rx_Data_valid) begin
            Address  <= Rx_Data[addr_width-1:0];
            RdEN     <= 1'b1;
            wait_cnt <= '0;
            state    <= RD_WAIT;
          end
        end
        OP_A: begin
          if (Rx_Data_valid) begin
            Address <= '0;
            WrData  <= Rx_Data;
            WrEN    <= 1'b1;
            state   <= OP_B;
          end
        end
        OP_B: begin
          if (Rx_Data_valid) begin
            Address <= addr_width'(1);
            WrData  <= Rx_Data;
            WrEN    <= 1'b1;
            state   <= FUN;
          end
        end
        FUN: begin
          if (Rx_Data_valid) begin
            ALU_FUN  <= Rx_Data[3:0];
            ALU_EN   <= 1'b1;
            wait_cnt <= '0;
            state    <= ALU_WAIT;
          end
        end
        RD_WAIT, ALU_WAIT: begin
          // Bytes are never consumed while waiting.
          if (Rx_Data_valid) begin
            Cmd_error <= 1'b1;
          end
          // A response on the limit cycle still wins over the timeout.
          if (resp) begin
            state       <= IDLE;
            Clk_gate_EN <= 1'b0;
          end else if (wait_cnt == LIMIT) begin
            Cmd_error   <= 1'b1;
            state       <= IDLE;
            Clk_gate_EN <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          Clk_gate_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_control.sv
// tb_rx_control: frame-level random stimulus with an event scoreboard.
// Expected strobes are queued by the driver and popped by a negedge monitor.
module tb_rx_control;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_valid;
  logic       alu_valid;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] addr;
  logic [7:0] wr_data;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       gate;
  logic       cmd_err;

  always #5 clk = ~clk;

  rx_control #(
    .width(8),
    .addr_width(4),
    .timeout(TO)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .Rx_Data(rx_data),
    .Rx_Data_valid(rx_valid),
    .Rd_valid(rd_valid),
    .ALU_out_valid(alu_valid),
    .WrEN(wr_en),
    .RdEN(rd_en),
    .Address(addr),
    .WrData(wr_data),
    .ALU_EN(alu_en),
    .ALU_FUN(alu_fun),
    .Clk_gate_EN(gate),
    .Cmd_error(cmd_err)
  );

  typedef enum int {EV_WR, EV_RD, EV_ALU, EV_ERR} ev_kind_t;
  typedef struct {
    int         cyc;
    ev_kind_t   kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t  sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic gate_exp = 1'b0;
  logic gate_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ev_ok(ev_t e, int c);
    if (e.cyc != c) return 1'b0;
    case (e.kind)
      EV_WR:
        return wr_en && !rd_en && !alu_en && !cmd_err &&
               addr == e.addr && wr_data == e.data;
      EV_RD:
        return rd_en && !wr_en && !alu_en && !cmd_err &&
               addr == e.addr;
      EV_ALU:
        return alu_en && !wr_en && !rd_en && !cmd_err &&
               alu_fun == e.data[3:0];
      default:
        return cmd_err && !wr_en && !rd_en && !alu_en;
    endcase
  endfunction

  // Monitor: pops one expected event per observed strobe cycle.
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_event: got no strobe, required %s at cyc %0d",
               e.kind.name(), e.cyc);
    end
    tests++;
    if (gate !== gate_exp) begin
      fails++;
      $display("FAIL clk_gate cyc %0d: got %b, required %b",
               cyc, gate, gate_exp);
    end
    if (wr_en || rd_en || alu_en || cmd_err) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe cyc %0d: got wr=%b rd=%b alu=%b err=%b, required none",
                 cyc, wr_en, rd_en, alu_en, cmd_err);
      end else begin
        e = sb.pop_front();
        if (!ev_ok(e, cyc)) begin
          fails++;
          $display("FAIL event cyc %0d: got wr=%b rd=%b alu=%b err=%b addr=%h data=%h fun=%h, required %s cyc %0d addr=%h data=%h",
                   cyc, wr_en, rd_en, alu_en, cmd_err, addr, wr_data,
                   alu_fun, e.kind.name(), e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_wren"}, {7'd0, wr_en}, 8'd0);
    chk({tag, "_rden"}, {7'd0, rd_en}, 8'd0);
    chk({tag, "_aluen"}, {7'd0, alu_en}, 8'd0);
    chk({tag, "_err"}, {7'd0, cmd_err}, 8'd0);
    chk({tag, "_gate"}, {7'd0, gate}, 8'd0);
    chk({tag, "_addr"}, {4'd0, addr}, 8'd0);
    chk({tag, "_wrdata"}, wr_data, 8'd0);
    chk({tag, "_fun"}, {4'd0, alu_fun}, 8'd0);
  endtask

  task automatic step(bit v, logic [7:0] d, bit rv, bit av);
    rx_valid  = v;
    rx_data   = d;
    rd_valid  = rv;
    alu_valid = av;
    @(posedge clk);
    #1;
    gate_exp  = gate_next;
    rx_valid  = 1'b0;
    rd_valid  = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic push(ev_kind_t k, logic [3:0] a, logic [7:0] d);
    sb.push_back('{cyc, k, a, d});
  endtask

  task automatic gap(int g);
    repeat ($urandom_range(0, g)) step(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send(logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  // Wait cycle k: response in cycle r succeeds (r <= TO); none -> error at TO.
  task automatic wait_phase(bit is_alu, int r, bit stray_rand, bit stray_at_r);
    for (int k = 0; k <= TO; k++) begin
      bit resp;
      bit stray;
      bit last;
      resp  = (k == r);
      stray = (stray_at_r && resp) ||
              (stray_rand && $urandom_range(0, 9) == 0);
      last  = resp || (k == TO);
      if (last && is_alu) gate_next = 1'b0;
      step(stray, 8'($urandom), !is_alu && resp, is_alu && resp);
      if (stray || (k == TO && !resp)) push(EV_ERR, 4'd0, 8'd0);
      if (last) break;
    end
  endtask

  task automatic wr_frame(logic [7:0] a, logic [7:0] d, int g);
    gap(g); send(8'hAA);
    gap(g); send(a);
    gap(g); send(d);
    push(EV_WR, a[3:0], d);
  endtask

  task automatic rd_frame(logic [7:0] a, int r, bit sr, bit sar, int g);
    gap(g); send(8'hBB);
    gap(g); send(a);
    push(EV_RD, a[3:0], 8'd0);
    wait_phase(1'b0, r, sr, sar);
  endtask

  task automatic alu_frame(bit ops, logic [7:0] x, logic [7:0] y,
                           logic [7:0] f, int r, bit sr, bit sar, int g);
    gap(g);
    gate_next = 1'b1;
    send(ops ? 8'hCC : 8'hDD);
    if (ops) begin
      gap(g); send(x);
      push(EV_WR, 4'd0, x);
      gap(g); send(y);
      push(EV_WR, 4'd1, y);
    end
    gap(g); send(f);
    push(EV_ALU, 4'd0, {4'd0, f[3:0]});
    wait_phase(1'b1, r, sr, sar);
  endtask

  task automatic bad_byte(logic [7:0] b, int g);
    gap(g); send(b);
    push(EV_ERR, 4'd0, 8'd0);
  endtask

  function automatic int pick_r();
    int s;
    s = $urandom_range(0, 9);
    if (s < 2) return TO;
    if (s < 4) return TO + 1 + $urandom_range(0, 3);
    return $urandom_range(0, TO - 1);
  endfunction

  function automatic logic [7:0] pick_bad();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
    return b;
  endfunction

  initial begin
    rst       = 1'b1;
    rx_data   = 8'd0;
    rx_valid  = 1'b0;
    rd_valid  = 1'b0;
    alu_valid = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b1);
    chk_all_zero("reset");
    rst = 1'b0;

    wr_frame(8'h05, 8'h3C, 0);
    rd_frame(8'h07, 3, 1'b0, 1'b0, 0);
    wr_frame(8'h0A, 8'h5A, 0);
    alu_frame(1'b1, 8'h12, 8'h34, 8'h02, 4, 1'b0, 1'b0, 0);
    bad_byte(8'h55, 0);
    alu_frame(1'b0, 8'h00, 8'h00, 8'h01, TO + 5, 1'b0, 1'b0, 0);
    alu_frame(1'b0, 8'h00, 8'h00, 8'h03, 2, 1'b0, 1'b1, 0);
    rd_frame(8'h03, TO, 1'b0, 1'b0, 0);

    send(8'hAA);
    send(8'h05);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_all_zero("midreset");
    rst = 1'b0;
    bad_byte(8'h3C, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: wr_frame(8'($urandom), 8'($urandom), 2);
        1: rd_frame(8'($urandom), pick_r(), 1'b1, 1'b0, 2);
        2: alu_frame(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
                     pick_r(), 1'b1, 1'($urandom), 2);
        3: alu_frame(1'b0, 8'd0, 8'd0, 8'($urandom),
                     pick_r(), 1'b1, 1'($urandom), 2);
        default: bad_byte(pick_bad(), 2);
      endcase
    end

    repeat (4) step(1'b0, 8'd0, 1'b0, 1'b0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_control.md
# rx_control

Receive-side system controller: consumes the byte stream delivered by the UART receiver, decodes command frames, and drives register-file writes and reads and ALU operations. It is the counterpart of the transmit-side controller. Its register-file read and ALU requests produce the `Rd_valid` and `ALU_out_valid` results that the transmit side serialises back. It waits for each result, or for a timeout, before accepting the next frame.

## Interface
- `width`, 8, data byte width.
- `addr_width`, 4, register-file address width.
- `timeout`, 16, maximum cycles to wait for `Rd_valid` / `ALU_out_valid`.

- `CLK`  in  1  system clock.
- `RST`  in  1  reset. Synchronous and active-high: clears the FSM and all outputs on a rising `CLK` edge while high.
- `Rx_Data`  in  width  received byte.
- `Rx_Data_valid`  in  1  one-cycle strobe qualifying `Rx_Data`.
- `Rd_valid`  in  1  register-file read data available.
- `ALU_out_valid`  in  1  ALU result available.
- `WrEN`  out  1  register-file write strobe (one cycle).
- `RdEN`  out  1  register-file read strobe (one cycle).
- `Address`  out  addr_width  register-file address.
- `WrData`  out  width  register-file write data.
- `ALU_EN`  out  1  ALU start strobe (one cycle).
- `ALU_FUN`  out  4  ALU function select.
- `Clk_gate_EN`  out  1  ALU clock-gate enable.
- `Cmd_error`  out  1  one-cycle error pulse.

## Operation
States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT.

A byte is accepted only in a cycle where `Rx_Data_valid` is 1. Transitions from IDLE on an accepted byte:
- 0xAA -> WR_ADDR.
  - WR_ADDR: the next byte latches `Address` = byte[addr_width-1:0] -> WR_DATA.
  - WR_DATA: the next byte sets `WrData` = byte and pulses `WrEN` -> IDLE.
- 0xBB -> RD_ADDR.
  - RD_ADDR: the next byte sets `Address` and pulses `RdEN` -> RD_WAIT.
- 0xCC -> OP_A.
  - OP_A: the byte is written to address 0 (`WrEN` pulse, `WrData` = byte) -> OP_B.
  - OP_B: the byte is written to address 1 -> FUN.
- 0xDD -> FUN.
  - FUN: the byte sets `ALU_FUN` = byte[3:0] and pulses `ALU_EN` -> ALU_WAIT.
- Any other byte: pulse `Cmd_error`, remain in IDLE.

Wait states:
- RD_WAIT exits to IDLE on `Rd_valid`.
- ALU_WAIT exits to IDLE on `ALU_out_valid`.
- A wait counter clears on entry and increments each cycle.
- If the counter reaches `timeout` without the response: pulse `Cmd_error` and go to IDLE.
- A response in the same cycle as the counter reaching the limit counts as success; no error.

Bytes arriving during RD_WAIT/ALU_WAIT are dropped and pulse `Cmd_error`. If a response and a byte arrive in the same cycle, the response completes the wait and the byte is dropped with the error pulse.

`Clk_gate_EN` is 1 from the cycle after 0xCC/0xDD is accepted until the cycle after ALU_WAIT exits, whether by response or by timeout.

`Address`, `WrData` and `ALU_FUN` hold their last value between commands. Strobes are 0 except in their single pulse cycle.

Reset mid-frame: the partial command is discarded, no strobe is issued, and the FSM returns to IDLE.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and the FSM is in IDLE.
- A strobe (`WrEN`, `RdEN`, `ALU_EN`, `Cmd_error`) is high in the cycle after the accepting `Rx_Data_valid` cycle. `Address`, `WrData` and `ALU_FUN` are updated in that same cycle.
- Back-to-back bytes, including consecutive cycles, are supported in every non-wait state. There is no minimum byte spacing.
- The wait counter starts at 0 in the first RD_WAIT/ALU_WAIT cycle. Timeout fires in cycle `timeout`, returning to IDLE on the next edge.
- The first byte of the next frame is accepted in the first IDLE cycle after a wait exit.

## Test plan
- Write: AA, 05, 3C -> one `WrEN` pulse with `Address`=5 and `WrData`=0x3C. `RdEN`, `ALU_EN` and `Cmd_error` stay 0.
- Read: BB, 07 -> `RdEN` pulse with `Address`=7. `Rd_valid` 3 cycles later -> IDLE. A following AA frame is accepted normally.
- ALU with operands: CC, 12, 34, 02 -> `WrEN` at address 0 with data 0x12, then `WrEN` at address 1 with data 0x34, then `ALU_EN` with `ALU_FUN`=2. `Clk_gate_EN` is high from after CC until after `ALU_out_valid`.
- Errors: a lone byte 0x55 -> one `Cmd_error` pulse, state IDLE. DD, 01 with no `ALU_out_valid` -> `Cmd_error` after 16 wait cycles and `Clk_gate_EN` drops.
- Simultaneous events:
  - In ALU_WAIT, `ALU_out_valid` and a byte in the same cycle -> return to IDLE, byte dropped, one `Cmd_error` pulse.
  - `Rd_valid` exactly at the timeout cycle -> no error.
- Reset: assert `RST` after AA, 05 -> no `WrEN`; all outputs 0. The subsequent byte 3C is treated as an unknown command -> `Cmd_error`.
